// File: rtl/sa_pkg.sv
// Shared types and sizing for the weight-stationary array sequencer.
package sa_pkg;
  localparam int N_DEF   = 4;
  localparam int M_W_DEF = 8;
  localparam int AW_DEF  = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_LOADW,
    S_STREAM,
    S_DONE
  } state_e;

  // Deepest tap is the last column's output: a_rd_en delayed N+(N-1) cycles.
  function automatic int skew_depth(input int n);
    return 2 * n - 1;
  endfunction

  localparam int SKEW_D = skew_depth(N_DEF);
  localparam int K_W    = (N_DEF > 1) ? $clog2(N_DEF) : 1;
  localparam int T_W    = M_W_DEF + 1;
endpackage

// File: rtl/ws_array_ctrl_if.sv
// Job control, SRAM read ports and array control/valid outputs of the sequencer.
interface ws_array_ctrl_if import sa_pkg::*; #(
  parameter int N   = N_DEF,
  parameter int M_W = M_W_DEF,
  parameter int AW  = AW_DEF
);
  logic             start;
  logic [M_W-1:0]   cfg_m;
  logic [AW-1:0]    cfg_w_base;
  logic [AW-1:0]    cfg_a_base;
  logic             busy;
  logic             done;
  logic             arr_clear;
  logic             arr_wload;
  logic             w_rd_en;
  logic [AW-1:0]    w_rd_addr;
  logic             a_rd_en;
  logic [AW-1:0]    a_rd_addr;
  logic [N-1:0]     a_row_en;
  logic [N-1:0]     out_col_vld;
  logic [N*M_W-1:0] out_vec_idx;

  modport master (
    output start, cfg_m, cfg_w_base, cfg_a_base,
    input  busy, done, arr_clear, arr_wload, w_rd_en, w_rd_addr,
           a_rd_en, a_rd_addr, a_row_en, out_col_vld, out_vec_idx
  );

  modport slave (
    input  start, cfg_m, cfg_w_base, cfg_a_base,
    output busy, done, arr_clear, arr_wload, w_rd_en, w_rd_addr,
           a_rd_en, a_rd_addr, a_row_en, out_col_vld, out_vec_idx
  );
endinterface

// File: rtl/sa_valid_skew.sv
// Shift line carrying {valid, vector index}; stage 0 is the live input, stage s is
// that input delayed s cycles. Row enables tap stages 0..N-1, column results N..2N-1.
module sa_valid_skew import sa_pkg::*; #(
  parameter int N   = N_DEF,
  parameter int M_W = M_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    in_vld,
  input  logic [M_W-1:0]          in_m,
  output logic [N-1:0]            row_en,
  output logic [N-1:0]            col_vld,
  output logic [N-1:0][M_W-1:0]   vec_idx
);
  localparam int SD = skew_depth(N);

  logic [SD:0]          vld_pipe;
  logic [SD:0][M_W-1:0] idx_pipe;
  logic [SD:1]          vld_q, vld_d;
  logic [SD:1][M_W-1:0] idx_q, idx_d;

  assign vld_pipe = {vld_q, in_vld};
  assign idx_pipe = {idx_q, in_m};

  // Advance one stage per cycle; an array clear also flushes anything in flight.
  always_comb begin
    vld_d = vld_pipe[SD-1:0];
    idx_d = idx_pipe[SD-1:0];
    if (clr) begin
      vld_d = '0;
      idx_d = '0;
    end
  end

  // Pipeline registers, emptied immediately on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      idx_q <= '0;
    end else begin
      vld_q <= vld_d;
      idx_q <= idx_d;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_tap
    assign row_en[i]  = vld_pipe[i];
    assign col_vld[i] = vld_pipe[N+i];
    assign vec_idx[i] = idx_pipe[N+i];
  end
endmodule

// File: rtl/ws_array_ctrl.sv
// Sequencer for the NxN weight-stationary array: clear, load weights, stream activations.
module ws_array_ctrl import sa_pkg::*; #(
  parameter int N   = N_DEF,
  parameter int M_W = M_W_DEF,
  parameter int AW  = AW_DEF
) (
  input  logic           clk,
  input  logic           rst,
  ws_array_ctrl_if.slave bus
);
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = M_W + 1;

  state_e         state_q, state_d;
  logic [KW-1:0]  k_q, k_d;
  logic [TW-1:0]  t_q, t_d;
  logic [M_W-1:0] m_q, m_d;
  logic [AW-1:0]  wb_q, wb_d, ab_q, ab_d;
  logic [TW-1:0]  t_last;

  logic           busy, done, clr, wload, w_en, a_en;
  logic [AW-1:0]  w_addr, a_addr;
  logic [M_W-1:0] a_m;
  logic [N-1:0][M_W-1:0] vec_idx;

  // Last STREAM cycle is when the final vector leaves the last column.
  assign t_last = TW'(m_q) + TW'(2 * N - 2);

  // Next state, counters, config latch and Moore outputs.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    t_d     = t_q;
    m_d     = m_q;
    wb_d    = wb_q;
    ab_d    = ab_q;
    busy    = 1'b0;
    done    = 1'b0;
    clr     = 1'b0;
    wload   = 1'b0;
    w_en    = 1'b0;
    w_addr  = '0;
    a_en    = 1'b0;
    a_addr  = '0;
    a_m     = '0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          m_d     = bus.cfg_m;
          wb_d    = bus.cfg_w_base;
          ab_d    = bus.cfg_a_base;
          state_d = S_CLR;
        end
      end
      S_CLR: begin
        busy    = 1'b1;
        clr     = 1'b1;
        k_d     = '0;
        state_d = S_LOADW;
      end
      S_LOADW: begin
        busy   = 1'b1;
        wload  = 1'b1;
        w_en   = 1'b1;
        // Bottom row goes in first; each cycle pushes the column chain down one row.
        w_addr = wb_q + AW'(N - 1) - AW'(k_q);
        if (k_q == KW'(N - 1)) begin
          t_d     = '0;
          state_d = (m_q != '0) ? S_STREAM : S_DONE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      S_STREAM: begin
        busy = 1'b1;
        if (t_q < TW'(m_q)) begin
          a_en   = 1'b1;
          a_addr = ab_q + AW'(t_q);
          a_m    = t_q[M_W-1:0];
        end
        if (t_q == t_last) state_d = S_DONE;
        else               t_d     = t_q + TW'(1);
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and job registers; reset abandons any job in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      t_q     <= '0;
      m_q     <= '0;
      wb_q    <= '0;
      ab_q    <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      t_q     <= t_d;
      m_q     <= m_d;
      wb_q    <= wb_d;
      ab_q    <= ab_d;
    end
  end

  sa_valid_skew #(.N(N), .M_W(M_W)) u_skew (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .in_vld  (a_en),
    .in_m    (a_m),
    .row_en  (bus.a_row_en),
    .col_vld (bus.out_col_vld),
    .vec_idx (vec_idx)
  );

  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.arr_clear   = clr;
  assign bus.arr_wload   = wload;
  assign bus.w_rd_en     = w_en;
  assign bus.w_rd_addr   = w_addr;
  assign bus.a_rd_en     = a_en;
  assign bus.a_rd_addr   = a_addr;
  assign bus.out_vec_idx = vec_idx;
endmodule

// File: tb/tb_ws_array_ctrl.sv
// Scoreboard bench: each job pushes its cycle-by-cycle expected outputs, the
// checker pops one record per cycle on the falling edge.
module tb_ws_array_ctrl;
  localparam int N   = 4;
  localparam int M_W = 8;
  localparam int AW  = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ws_array_ctrl_if #(.N(N), .M_W(M_W), .AW(AW)) bus ();
  ws_array_ctrl #(.N(N), .M_W(M_W), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic             busy, done, clr, wload, w_en, a_en;
    logic [AW-1:0]    w_addr, a_addr;
    logic [N-1:0]     row_en, col_vld;
    logic [N-1:0][M_W-1:0] idx;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t blank();
    exp_t e;
    e.busy = 0; e.done = 0; e.clr = 0; e.wload = 0; e.w_en = 0; e.a_en = 0;
    e.w_addr = '0; e.a_addr = '0; e.row_en = '0; e.col_vld = '0; e.idx = '0;
    return e;
  endfunction

  // Expected trace from the job's closed-form schedule: CLR, N LOADW, STREAM, DONE, one IDLE.
  task automatic push_job(input int m, input logic [7:0] wb, input logic [7:0] ab);
    exp_t e;
    e = blank(); e.busy = 1; e.clr = 1; exp_q.push_back(e);
    for (int k = 0; k < N; k++) begin
      e = blank(); e.busy = 1; e.wload = 1; e.w_en = 1;
      e.w_addr = wb + 8'(N - 1 - k);
      exp_q.push_back(e);
    end
    if (m > 0) begin
      for (int t = 0; t <= m + 2 * N - 2; t++) begin
        e = blank(); e.busy = 1;
        if (t < m) begin e.a_en = 1; e.a_addr = ab + 8'(t); end
        for (int i = 0; i < N; i++) begin
          e.row_en[i]  = (t - i >= 0) && (t - i < m);
          e.col_vld[i] = (t - N - i >= 0) && (t - N - i < m);
          e.idx[i]     = 8'(t - N - i);
        end
        exp_q.push_back(e);
      end
    end
    e = blank(); e.done = 1; exp_q.push_back(e);
    e = blank(); exp_q.push_back(e);
  endtask

  task automatic cmp_cycle(input int c);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk($sformatf("q_empty[%0d]", c), 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    chk($sformatf("busy[%0d]", c),    bus.busy,        e.busy);
    chk($sformatf("done[%0d]", c),    bus.done,        e.done);
    chk($sformatf("clear[%0d]", c),   bus.arr_clear,   e.clr);
    chk($sformatf("wload[%0d]", c),   bus.arr_wload,   e.wload);
    chk($sformatf("w_en[%0d]", c),    bus.w_rd_en,     e.w_en);
    chk($sformatf("a_en[%0d]", c),    bus.a_rd_en,     e.a_en);
    chk($sformatf("row_en[%0d]", c),  bus.a_row_en,    e.row_en);
    chk($sformatf("col_vld[%0d]", c), bus.out_col_vld, e.col_vld);
    if (e.w_en) chk($sformatf("w_addr[%0d]", c), bus.w_rd_addr, e.w_addr);
    if (e.a_en) chk($sformatf("a_addr[%0d]", c), bus.a_rd_addr, e.a_addr);
    for (int j = 0; j < N; j++)
      if (e.col_vld[j])
        chk($sformatf("vec_idx%0d[%0d]", j, c), bus.out_vec_idx[j*M_W +: M_W], e.idx[j]);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"},  bus.busy,        32'd0);
    chk({tag, "_done"},  bus.done,        32'd0);
    chk({tag, "_clr"},   bus.arr_clear,   32'd0);
    chk({tag, "_wload"}, bus.arr_wload,   32'd0);
    chk({tag, "_w_en"},  bus.w_rd_en,     32'd0);
    chk({tag, "_a_en"},  bus.a_rd_en,     32'd0);
    chk({tag, "_a_adr"}, bus.a_rd_addr,   32'd0);
    chk({tag, "_row"},   bus.a_row_en,    32'd0);
    chk({tag, "_col"},   bus.out_col_vld, 32'd0);
    chk({tag, "_idx"},   bus.out_vec_idx, 32'd0);
  endtask

  // Called at a falling edge with the DUT idle. Optional start pokes during LOADW
  // and DONE, optional reset at a given cycle of the job.
  task automatic run_job(input int m, input logic [7:0] wb, input logic [7:0] ab,
                         input bit poke_ld, input bit poke_dn, input int abort_at);
    int n;
    push_job(m, wb, ab);
    n = exp_q.size();
    bus.cfg_m = 8'(m); bus.cfg_w_base = wb; bus.cfg_a_base = ab; bus.start = 1'b1;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      cmp_cycle(c);
      if (c == abort_at) begin
        rst = 1'b1;
        #1;
        chk_quiet("async_rst");
        for (int r = 0; r < 3; r++) begin
          @(negedge clk);
          chk($sformatf("rst_done%0d", r), bus.done, 32'd0);
          chk($sformatf("rst_busy%0d", r), bus.busy, 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk_quiet("post_rst");
        exp_q.delete();
        return;
      end
      if ((poke_ld && c == 1) || (poke_dn && c == n - 2)) begin
        bus.start = 1'b1; bus.cfg_m = 8'd7; bus.cfg_w_base = 8'hA0; bus.cfg_a_base = 8'h55;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.cfg_m = '0; bus.cfg_w_base = '0; bus.cfg_a_base = '0;
    repeat (2) @(negedge clk);
    chk_quiet("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_quiet("idle");

    run_job(3, 8'h10, 8'h00, 0, 0, -1);   // basic job, N=4 M=3
    run_job(0, 8'h20, 8'h00, 0, 0, -1);   // M=0: no streaming
    run_job(2, 8'h30, 8'h40, 1, 1, -1);   // start during LOADW and DONE ignored
    run_job(1, 8'h08, 8'h60, 0, 0, -1);   // second job only after IDLE start
    run_job(3, 8'h10, 8'h00, 0, 0, 7);    // reset at STREAM t=2
    run_job(3, 8'h50, 8'h20, 0, 0, -1);   // clean job after reset
    run_job(4, 8'hFE, 8'hFE, 0, 0, -1);   // address wrap on both ports
    run_job(5, 8'h01, 8'h7C, 0, 0, -1);   // M > N

    repeat (2) @(negedge clk);
    chk_quiet("final");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
